// File: rtl/drum_voice_scheduler_if.sv
// Trigger/tick inputs and playback-state outputs shared between the trigger mux and the drum voice scheduler.
interface drum_voice_scheduler_if;
   logic        sample_tick;
   logic [4:0]  trig;
   logic [11:0] rom_addr;
   logic [2:0]  voice;
   logic [2:0]  voice_d;
   logic        active;
   logic [4:0]  pending;

   modport master (
      output sample_tick, trig,
      input  rom_addr, voice, voice_d, active, pending
   );

   modport slave (
      input  sample_tick, trig,
      output rom_addr, voice, voice_d, active, pending
   );
endinterface

// File: rtl/drum_voice_scheduler.sv
// Shared drum-sample engine scheduler: latches triggers, grants by priority, steps the ROM address.
// Optional feature: define DRUM_PREEMPT_EN to let higher-priority requests preempt the playing voice.
module drum_voice_scheduler #(
   parameter int unsigned LEN_CYMBAL = 2451,
   parameter int unsigned LEN_HIHAT  = 486,
   parameter int unsigned LEN_TOM    = 3211,
   parameter int unsigned LEN_SNARE  = 729,
   parameter int unsigned LEN_KICK   = 2029
) (
   input  logic                  clk,
   input  logic                  rst_n,
   drum_voice_scheduler_if.slave bus
);

   typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;

   state_t      state_r, state_s;
   logic [11:0] rom_addr_r, rom_addr_s;
   logic [2:0]  voice_r, voice_s, voice_d_r;
   logic [4:0]  pending_r, pending_s;
   logic        active_r;
   logic [4:0]  req_s, grant_bit_s, cur_bit_s, pend_play_s;
   logic [2:0]  grant_code_s;

   function automatic logic [2:0] prio_code(input logic [4:0] r);
      if (r[4])      prio_code = 3'd5;
      else if (r[3]) prio_code = 3'd4;
      else if (r[2]) prio_code = 3'd3;
      else if (r[1]) prio_code = 3'd2;
      else if (r[0]) prio_code = 3'd1;
      else           prio_code = 3'd0;
   endfunction

   function automatic logic [4:0] code_bit(input logic [2:0] c);
      case (c)
         3'd1:    code_bit = 5'b00001;
         3'd2:    code_bit = 5'b00010;
         3'd3:    code_bit = 5'b00100;
         3'd4:    code_bit = 5'b01000;
         3'd5:    code_bit = 5'b10000;
         default: code_bit = 5'b00000;
      endcase
   endfunction

   function automatic logic [11:0] last_addr(input logic [2:0] c);
      case (c)
         3'd1:    last_addr = 12'(LEN_CYMBAL - 32'd1);
         3'd2:    last_addr = 12'(LEN_HIHAT - 32'd1);
         3'd3:    last_addr = 12'(LEN_TOM - 32'd1);
         3'd4:    last_addr = 12'(LEN_SNARE - 32'd1);
         3'd5:    last_addr = 12'(LEN_KICK - 32'd1);
         default: last_addr = 12'd0;
      endcase
   endfunction

`ifdef DRUM_PREEMPT_EN
   function automatic logic [4:0] higher_mask(input logic [2:0] c);
      case (c)
         3'd1:    higher_mask = 5'b11110;
         3'd2:    higher_mask = 5'b11100;
         3'd3:    higher_mask = 5'b11000;
         3'd4:    higher_mask = 5'b10000;
         default: higher_mask = 5'b00000;
      endcase
   endfunction
`endif

   // Next-state, grant and address stepping; retrigger outranks tick and end-of-sound.
   always_comb begin
      state_s      = state_r;
      rom_addr_s   = rom_addr_r;
      voice_s      = voice_r;
      req_s        = pending_r | bus.trig;
      grant_code_s = prio_code(req_s);
      grant_bit_s  = code_bit(grant_code_s);
      cur_bit_s    = code_bit(voice_r);
      pend_play_s  = pending_r | (bus.trig & ~cur_bit_s);
      pending_s    = pending_r;
      case (state_r)
         IDLE: begin
            pending_s = req_s & ~grant_bit_s;
            if (req_s != 5'b00000) begin
               state_s    = PLAY;
               voice_s    = grant_code_s;
               rom_addr_s = 12'd0;
            end else begin
               state_s    = IDLE;
            end
         end
         PLAY: begin
            pending_s = pend_play_s;
`ifdef DRUM_PREEMPT_EN
            if ((req_s & higher_mask(voice_r)) != 5'b00000) begin
               voice_s    = grant_code_s;
               rom_addr_s = 12'd0;
               pending_s  = pend_play_s & ~grant_bit_s;
            end else
`endif
            if ((bus.trig & cur_bit_s) != 5'b00000) begin
               rom_addr_s = 12'd0;
            end else if (bus.sample_tick) begin
               if (rom_addr_r == last_addr(voice_r)) begin
                  state_s    = IDLE;
                  voice_s    = 3'd0;
                  rom_addr_s = 12'd0;
               end else begin
                  rom_addr_s = rom_addr_r + 12'd1;
               end
            end else begin
               rom_addr_s = rom_addr_r;
            end
         end
         default: begin
            state_s    = IDLE;
            voice_s    = 3'd0;
            rom_addr_s = 12'd0;
            pending_s  = 5'b00000;
         end
      endcase
   end

   // State and output registers; voice_d tracks the one-cycle ROM read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         rom_addr_r <= 12'd0;
         voice_r    <= 3'd0;
         voice_d_r  <= 3'd0;
         pending_r  <= 5'b00000;
         active_r   <= 1'b0;
      end else begin
         state_r    <= state_s;
         rom_addr_r <= rom_addr_s;
         voice_r    <= voice_s;
         voice_d_r  <= voice_r;
         pending_r  <= pending_s;
         active_r   <= (state_s == PLAY);
      end
   end

   assign bus.rom_addr = rom_addr_r;
   assign bus.voice    = voice_r;
   assign bus.voice_d  = voice_d_r;
   assign bus.active   = active_r;
   assign bus.pending  = pending_r;

endmodule

// File: tb/tb_drum_voice_scheduler.sv
// Scoreboard bench for drum_voice_scheduler; follows DRUM_PREEMPT_EN the same way as the design.
module tb_drum_voice_scheduler;

   typedef struct packed {
      logic [2:0]  voice;
      logic [2:0]  voice_d;
      logic [11:0] addr;
      logic        active;
      logic [4:0]  pending;
   } obs_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [2:0] prev_v;
   obs_t exp_q[$];

   drum_voice_scheduler_if u_if ();

   drum_voice_scheduler dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected voice_d is the bench's own expected voice from the previous clock.
   task automatic push_exp(input logic [2:0] v, input logic [11:0] a, input logic act, input logic [4:0] p);
      obs_t e;
      e.voice   = v;
      e.voice_d = prev_v;
      e.addr    = a;
      e.active  = act;
      e.pending = p;
      prev_v    = v;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input logic [4:0] t, input logic tick);
      u_if.trig        = t;
      u_if.sample_tick = tick;
      @(posedge clk);
      #1;
      u_if.trig        = 5'b00000;
      u_if.sample_tick = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      prev_v = 3'd0;
      exp_q.delete();
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.voice   = u_if.voice;
      o.voice_d = u_if.voice_d;
      o.addr    = u_if.rom_addr;
      o.active  = u_if.active;
      o.pending = u_if.pending;
      return o;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("v=%0d vd=%0d addr=%0d act=%0b pend=%b", o.voice, o.voice_d, o.addr, o.active, o.pending);
   endfunction

   task automatic test_reset();
      obs_t e, o;
      #3;
      push_exp(3'd0, 12'd0, 1'b0, 5'b00000);
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_state: got %s, expected %s", fmt(o), fmt(e)); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_exp(3'd0, 12'd0, 1'b0, 5'b00000);
         cyc(5'b00000, (i != 2));
         e = exp_q.pop_front(); o = sample(); checks++;
         if (o !== e) begin errors++; $display("FAIL idle_tick[%0d]: got %s, expected %s", i, fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_hihat();
      obs_t e, o;
      do_reset();
      for (int i = 0; i <= 486; i++) begin
         if (i == 0) begin
            push_exp(3'd2, 12'd0, 1'b1, 5'b00000); cyc(5'b00010, 1'b0);
         end else if (i < 486) begin
            push_exp(3'd2, 12'(i), 1'b1, 5'b00000); cyc(5'b00000, 1'b1);
         end else begin
            push_exp(3'd0, 12'd0, 1'b0, 5'b00000); cyc(5'b00000, 1'b1);
         end
         e = exp_q.pop_front(); o = sample(); checks++;
         if (o !== e) begin errors++; $display("FAIL hihat[%0d]: got %s, expected %s", i, fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_priority();
      obs_t e, o;
      do_reset();
      for (int i = 0; i <= 2030; i++) begin
         if (i == 0) begin
            push_exp(3'd5, 12'd0, 1'b1, 5'b00001); cyc(5'b10001, 1'b0);
         end else if (i < 2029) begin
            push_exp(3'd5, 12'(i), 1'b1, 5'b00001); cyc(5'b00000, 1'b1);
         end else if (i == 2029) begin
            push_exp(3'd0, 12'd0, 1'b0, 5'b00001); cyc(5'b00000, 1'b1);
         end else begin
            push_exp(3'd1, 12'd0, 1'b1, 5'b00000); cyc(5'b00000, 1'b0);
         end
         e = exp_q.pop_front(); o = sample(); checks++;
         if (o !== e) begin errors++; $display("FAIL priority[%0d]: got %s, expected %s", i, fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_retrigger();
      obs_t e, o;
      do_reset();
      for (int i = 0; i <= 832; i++) begin
         if (i == 0) begin
            push_exp(3'd4, 12'd0, 1'b1, 5'b00000); cyc(5'b01000, 1'b0);
         end else if (i <= 100) begin
            push_exp(3'd4, 12'(i), 1'b1, 5'b00000); cyc(5'b00000, 1'b1);
         end else if (i == 101) begin
            push_exp(3'd4, 12'd0, 1'b1, 5'b00000); cyc(5'b01000, 1'b1);
         end else if (i <= 829) begin
            push_exp(3'd4, 12'(i - 101), 1'b1, 5'b00000); cyc(5'b00000, 1'b1);
         end else if (i == 830) begin
            push_exp(3'd0, 12'd0, 1'b0, 5'b00001); cyc(5'b00001, 1'b1);
         end else if (i == 831) begin
            push_exp(3'd1, 12'd0, 1'b1, 5'b00000); cyc(5'b00000, 1'b0);
         end else begin
            push_exp(3'd1, 12'd1, 1'b1, 5'b00000); cyc(5'b00000, 1'b1);
         end
         e = exp_q.pop_front(); o = sample(); checks++;
         if (o !== e) begin errors++; $display("FAIL retrigger[%0d]: got %s, expected %s", i, fmt(o), fmt(e)); end
      end
   endtask

   task automatic test_cymbal_kick();
      obs_t e, o;
      int   n;
      do_reset();
`ifdef DRUM_PREEMPT_EN
      n = 8;
`else
      n = 2452;
`endif
      for (int i = 0; i <= n; i++) begin
         if (i == 0) begin
            push_exp(3'd1, 12'd0, 1'b1, 5'b00000); cyc(5'b00001, 1'b0);
         end else if (i <= 5) begin
            push_exp(3'd1, 12'(i), 1'b1, 5'b00000); cyc(5'b00000, 1'b1);
`ifdef DRUM_PREEMPT_EN
         end else if (i <= 7) begin
            push_exp(3'd5, 12'd0, 1'b1, 5'b00000); cyc(5'b10000, (i == 6));
         end else begin
            push_exp(3'd5, 12'd1, 1'b1, 5'b00000); cyc(5'b00000, 1'b1);
`else
         end else if (i <= 7) begin
            push_exp(3'd1, 12'd6, 1'b1, 5'b10000); cyc(5'b10000, (i == 6));
         end else if (i <= 2451) begin
            push_exp(3'd1, 12'(i - 1), 1'b1, 5'b10000); cyc(5'b00000, 1'b1);
         end else begin
            push_exp(3'd0, 12'd0, 1'b0, 5'b10000); cyc(5'b00000, 1'b1);
`endif
         end
         e = exp_q.pop_front(); o = sample(); checks++;
         if (o !== e) begin errors++; $display("FAIL cymbal_kick[%0d]: got %s, expected %s", i, fmt(o), fmt(e)); end
      end
`ifndef DRUM_PREEMPT_EN
      push_exp(3'd5, 12'd0, 1'b1, 5'b00000); cyc(5'b00000, 1'b0);
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL kick_after_cymbal: got %s, expected %s", fmt(o), fmt(e)); end
`endif
   endtask

   task automatic test_async_reset();
      obs_t e, o;
      do_reset();
      for (int i = 0; i <= 2000; i++) begin
         push_exp(3'd3, 12'(i), 1'b1, 5'b00000);
         cyc((i == 0) ? 5'b00100 : 5'b00000, (i != 0));
         e = exp_q.pop_front(); o = sample(); checks++;
         if (o !== e) begin errors++; $display("FAIL tom[%0d]: got %s, expected %s", i, fmt(o), fmt(e)); end
      end
      #2;
      rst_n  = 1'b0;
      prev_v = 3'd0;
      #1;
      push_exp(3'd0, 12'd0, 1'b0, 5'b00000);
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL tom_async_reset: got %s, expected %s", fmt(o), fmt(e)); end
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_exp(3'd3, 12'(i), 1'b1, 5'b00000);
         cyc((i == 0) ? 5'b00100 : 5'b00000, (i != 0));
         e = exp_q.pop_front(); o = sample(); checks++;
         if (o !== e) begin errors++; $display("FAIL tom_restart[%0d]: got %s, expected %s", i, fmt(o), fmt(e)); end
      end
   endtask

   initial begin
      rst_n            = 1'b0;
      prev_v           = 3'd0;
      u_if.trig        = 5'b00000;
      u_if.sample_tick = 1'b0;
      test_reset();
      test_hihat();
      test_priority();
      test_retrigger();
      test_cymbal_kick();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/drum_voice_scheduler.md
# drum_voice_scheduler

Sequences the single shared drum-sample playback engine: it latches one-cycle trigger requests from the five drum sources, picks which voice owns the engine, and steps the common ROM address on the sample-rate tick. It sits between the trigger mux (live debounced buttons or looper playback triggers) and the five audio ROMs, the ROM output mux and the PWM DAC. It replaces ad-hoc first-come playback logic: no trigger is silently lost while another sound plays, and every voice gets a distinct select code.

## Interface
- LEN_CYMBAL, 2451: cymbal sample count; last address is LEN_CYMBAL-1.
- LEN_HIHAT, 486: hihat sample count.
- LEN_TOM, 3211: tom sample count.
- LEN_SNARE, 729: snare sample count.
- LEN_KICK, 2029: kick sample count.
- Every LEN_* must be in 1..4096.

- clk  in  1  system clock, 48 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle pulse at the sample rate.
- trig  in  5  one-cycle trigger pulses: bit0 cymbal, bit1 hihat, bit2 tom, bit3 snare, bit4 kick.
- rom_addr  out  12  shared ROM address.
- voice  out  3  owning voice: 0 silence, 1 cymbal, 2 hihat, 3 tom, 4 snare, 5 kick.
- voice_d  out  3  voice delayed 1 clk; aligned with the 1-cycle ROM read latency; drives the sample mux.
- active  out  1  engine busy (PLAY state).
- pending  out  5  latched, not-yet-granted requests, same bit order as trig.

## Operation
- States: IDLE, PLAY.
- Reset: IDLE; rom_addr=0, voice=0, voice_d=0, active=0, pending=0.
- Request set: req = pending | trig.
- Priority for grant: kick > snare > tom > hihat > cymbal.

- IDLE with req≠0:
  - Grant the highest-priority bit.
  - rom_addr=0, voice=code, active=1, next state PLAY.
  - Clear the granted bit; keep the other req bits in pending.

- PLAY:
  - trig bits for other voices set pending.
  - On sample_tick with rom_addr≠LEN(voice)-1: rom_addr+1.
  - On sample_tick with rom_addr=LEN(voice)-1: go IDLE, voice=0, rom_addr=0, active=0.

- Retrigger: trig bit of the currently playing voice restarts it at rom_addr=0 and does not set pending. Retrigger wins over a same-cycle sample_tick or end-of-sound.
- End-of-sound with a same-cycle trig for a different voice: go IDLE, trig enters pending, grant on the next clk.
- A pending bit is set once per source; repeated triggers of a voice already pending merge and are not counted.
- Address arithmetic is 12-bit unsigned. It never wraps, because end-of-sound is detected at LEN-1.
- rst_n assertion mid-sound: immediate silence; all state returns to reset values asynchronously.

## Timing
- Trigger to grant when idle: 1 clk. voice, rom_addr=0 and active are valid after the edge that samples trig.
- voice_d lags voice by exactly 1 clk.
- One sample_tick advances rom_addr by exactly 1. Ticks in IDLE are ignored.
- Sound end to next grant: 1 clk, with one IDLE cycle between sounds.
- Playback duration is LEN ticks: from the grant through the tick that exits at address LEN-1.

## Configuration
- DRUM_PREEMPT_EN defined:
  - In PLAY, a pending or triggered voice of strictly higher priority than the current voice preempts it on that clk.
  - The new voice is granted with rom_addr=0. The preempted voice is dropped and not re-queued.
  - The preemptor's pending bit is cleared.
- DRUM_PREEMPT_EN undefined:
  - No preemption; higher-priority requests wait in pending until end-of-sound.

## Test plan
- Reset, then trig=5'b00010 (hihat) → next clk voice=2, active=1, rom_addr=0. After 486 sample_ticks: voice=0, active=0.
- Idle, trig=5'b10001 in the same clk → kick granted (voice=5), pending=5'b00001. After kick ends: 1 IDLE clk, then voice=1.
- Snare playing at rom_addr=100, trig snare coincident with sample_tick → rom_addr=0, voice stays 4, pending=0.
- Cymbal playing, trig kick. DRUM_PREEMPT_EN undefined → pending=5'b10000, cymbal completes. Defined → next clk voice=5, rom_addr=0, pending=0.
- Tom at rom_addr=2000, rst_n pulsed low mid-clock → outputs immediately 0 without a clk edge. After release, trig tom → voice=3 from rom_addr=0.
- voice_d check: after any grant, voice_d equals the previous cycle's voice on every clk across a full sound.
